// File: rtl/aclock_pkg.sv
// rtl/aclock_pkg.sv - shared state encoding and BCD limits for the clock set controller
package aclock_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    T_HR   = 3'd1,
    T_MIN  = 3'd2,
    T_LOAD = 3'd3,
    A_HR   = 3'd4,
    A_MIN  = 3'd5,
    A_LOAD = 3'd6
  } set_state_e;

  localparam logic [1:0] HR_MAX_TENS       = 2'd2;
  localparam logic [3:0] HR_MAX_UNITS_AT_2 = 4'd3;
  localparam logic [3:0] MIN_MAX_TENS      = 4'd5;
  localparam logic [3:0] BCD_MAX           = 4'd9;

  function automatic logic is_edit(input set_state_e s);
    return (s == T_HR) || (s == T_MIN) || (s == A_HR) || (s == A_MIN);
  endfunction

  function automatic logic is_min(input set_state_e s);
    return (s == T_MIN) || (s == A_MIN);
  endfunction

endpackage

// File: rtl/bcd_time_inc.sv
// rtl/bcd_time_inc.sv - combinational BCD hour/minute incrementer with field select
module bcd_time_inc
  import aclock_pkg::*;
(
  input  logic       sel_min,
  input  logic [1:0] h1_i,
  input  logic [3:0] h0_i,
  input  logic [3:0] m1_i,
  input  logic [3:0] m0_i,
  output logic [1:0] h1_o,
  output logic [3:0] h0_o,
  output logic [3:0] m1_o,
  output logic [3:0] m0_o
);

  always_comb begin
    h1_o = h1_i;
    h0_o = h0_i;
    m1_o = m1_i;
    m0_o = m0_i;
    if (sel_min) begin
      // minutes wrap on their own; hours are never carried into
      if (m0_i == BCD_MAX) begin
        m0_o = 4'd0;
        m1_o = (m1_i == MIN_MAX_TENS) ? 4'd0 : m1_i + 4'd1;
      end else begin
        m0_o = m0_i + 4'd1;
      end
    end else begin
      if ((h1_i == HR_MAX_TENS) && (h0_i == HR_MAX_UNITS_AT_2)) begin
        h1_o = 2'd0;
        h0_o = 4'd0;
      end else if (h0_i == BCD_MAX) begin
        h1_o = h1_i + 2'd1;
        h0_o = 4'd0;
      end else begin
        h0_o = h0_i + 4'd1;
      end
    end
  end

endmodule

// File: rtl/aclock_set_ctrl.sv
// rtl/aclock_set_ctrl.sv - front-panel set FSM driving the Aclock digit bus and load strobes
module aclock_set_ctrl
  import aclock_pkg::*;
#(
  parameter int unsigned LOAD_CYCLES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 30,
  parameter int unsigned REPEAT_DELAY   = 8,
  parameter int unsigned REPEAT_RATE    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_set,
  input  logic       btn_aset,
  input  logic       btn_inc,
  input  logic       btn_al,
  input  logic       btn_stop,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic       STOP_al,
  output logic       AL_ON,
  output logic [2:0] set_state
);

  localparam int CW = 16;
  localparam int B_SET  = 0;
  localparam int B_ASET = 1;
  localparam int B_INC  = 2;
  localparam int B_AL   = 3;
  localparam int B_STOP = 4;

  set_state_e state_q, state_d;
  logic [CW-1:0] dwell_q, dwell_d;
  logic [CW-1:0] rep_cnt_q, rep_cnt_d;
  logic rep_run_q, rep_run_d;
  logic [4:0] btn_prev_q, btn_prev_d;
  logic [1:0] h1_q, h1_d;
  logic [3:0] h0_q, h0_d, m1_q, m1_d, m0_q, m0_d;
  logic ld_time_q, ld_time_d, ld_alarm_q, ld_alarm_d;
  logic stop_q, stop_d, al_on_q, al_on_d;

  logic [4:0] btn_now, press;
  logic adv, any_press, edit, rep_fire, inc_en;
  logic [1:0] h1_inc;
  logic [3:0] h0_inc, m1_inc, m0_inc;

  assign btn_now   = {btn_stop, btn_al, btn_inc, btn_aset, btn_set};
  assign press     = btn_now & ~btn_prev_q;
  assign adv       = press[B_SET] | press[B_ASET];
  assign any_press = |press;
  assign edit      = is_edit(state_q);
  // first repeat after REPEAT_DELAY held cycles, then one every REPEAT_RATE cycles
  assign rep_fire  = edit && btn_inc && btn_prev_q[B_INC] &&
                     (rep_run_q ? (rep_cnt_q == CW'(REPEAT_RATE))
                                : (rep_cnt_q == CW'(REPEAT_DELAY)));
  assign inc_en    = edit && !adv && (press[B_INC] || rep_fire);

  bcd_time_inc u_inc (
    .sel_min (is_min(state_q)),
    .h1_i    (h1_q),
    .h0_i    (h0_q),
    .m1_i    (m1_q),
    .m0_i    (m0_q),
    .h1_o    (h1_inc),
    .h0_o    (h0_inc),
    .m1_o    (m1_inc),
    .m0_o    (m0_inc)
  );

  always_comb begin
    state_d    = state_q;
    dwell_d    = dwell_q;
    rep_cnt_d  = rep_cnt_q;
    rep_run_d  = rep_run_q;
    btn_prev_d = btn_now;
    h1_d       = h1_q;
    h0_d       = h0_q;
    m1_d       = m1_q;
    m0_d       = m0_q;

    unique case (state_q)
      IDLE: begin
        dwell_d = '0;
        if (press[B_SET])       state_d = T_HR;
        else if (press[B_ASET]) state_d = A_HR;
      end
      T_HR, T_MIN, A_HR, A_MIN: begin
        if (adv) begin
          dwell_d = '0;
          case (state_q)
            T_HR:    state_d = T_MIN;
            T_MIN:   state_d = T_LOAD;
            A_HR:    state_d = A_MIN;
            default: state_d = A_LOAD;
          endcase
        end else if (any_press) begin
          dwell_d = '0;
        end else if (dwell_q == CW'(TIMEOUT_CYCLES - 1)) begin
          dwell_d = '0;
          state_d = IDLE;
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      T_LOAD, A_LOAD: begin
        if (dwell_q == CW'(LOAD_CYCLES - 1)) begin
          dwell_d = '0;
          state_d = IDLE;
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      default: begin
        dwell_d = '0;
        state_d = IDLE;
      end
    endcase

    if (!btn_inc || !edit) begin
      rep_cnt_d = '0;
      rep_run_d = 1'b0;
    end else if (press[B_INC]) begin
      rep_cnt_d = CW'(1);
      rep_run_d = 1'b0;
    end else if (rep_fire) begin
      rep_cnt_d = CW'(1);
      rep_run_d = 1'b1;
    end else if (rep_cnt_q != '1) begin
      rep_cnt_d = rep_cnt_q + 1'b1;
    end

    if (inc_en) begin
      h1_d = h1_inc;
      h0_d = h0_inc;
      m1_d = m1_inc;
      m0_d = m0_inc;
    end

    ld_time_d  = (state_d == T_LOAD);
    ld_alarm_d = (state_d == A_LOAD);
    stop_d     = press[B_STOP];
    al_on_d    = al_on_q ^ press[B_AL];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      dwell_q    <= '0;
      rep_cnt_q  <= '0;
      rep_run_q  <= 1'b0;
      btn_prev_q <= '0;
      h1_q       <= '0;
      h0_q       <= '0;
      m1_q       <= '0;
      m0_q       <= '0;
      ld_time_q  <= 1'b0;
      ld_alarm_q <= 1'b0;
      stop_q     <= 1'b0;
      al_on_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      dwell_q    <= dwell_d;
      rep_cnt_q  <= rep_cnt_d;
      rep_run_q  <= rep_run_d;
      btn_prev_q <= btn_prev_d;
      h1_q       <= h1_d;
      h0_q       <= h0_d;
      m1_q       <= m1_d;
      m0_q       <= m0_d;
      ld_time_q  <= ld_time_d;
      ld_alarm_q <= ld_alarm_d;
      stop_q     <= stop_d;
      al_on_q    <= al_on_d;
    end
  end

  assign H_in1     = h1_q;
  assign H_in0     = h0_q;
  assign M_in1     = m1_q;
  assign M_in0     = m0_q;
  assign LD_time   = ld_time_q;
  assign LD_alarm  = ld_alarm_q;
  assign STOP_al   = stop_q;
  assign AL_ON     = al_on_q;
  assign set_state = state_q;

endmodule

// File: tb/tb_aclock_set_ctrl.sv
// tb/tb_aclock_set_ctrl.sv - directed self-checking bench for aclock_set_ctrl
module tb_aclock_set_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] btns = '0;
  logic [1:0] h_in1;
  logic [3:0] h_in0, m_in1, m_in0;
  logic ld_time, ld_alarm, stop_al, al_on;
  logic [2:0] set_state;

  int checks = 0;
  int errors = 0;
  int cnt_a, cnt_b;

  localparam logic [4:0] SET  = 5'b00001;
  localparam logic [4:0] ASET = 5'b00010;
  localparam logic [4:0] INC  = 5'b00100;
  localparam logic [4:0] AL   = 5'b01000;
  localparam logic [4:0] STOP = 5'b10000;

  always #5 clk = ~clk;

  aclock_set_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .btn_set   (btns[0]),
    .btn_aset  (btns[1]),
    .btn_inc   (btns[2]),
    .btn_al    (btns[3]),
    .btn_stop  (btns[4]),
    .H_in1     (h_in1),
    .H_in0     (h_in0),
    .M_in1     (m_in1),
    .M_in0     (m_in0),
    .LD_time   (ld_time),
    .LD_alarm  (ld_alarm),
    .STOP_al   (stop_al),
    .AL_ON     (al_on),
    .set_state (set_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [4:0] m, input int times);
    repeat (times) begin
      btns = m;
      tick(1);
      btns = '0;
      tick(1);
    end
  endtask

  task automatic check_time(input string tag, input int hh, input int mm);
    check({tag, "_h"}, {h_in1, h_in0}, {2'(hh / 10), 4'(hh % 10)});
    check({tag, "_m"}, {m_in1, m_in0}, {4'(mm / 10), 4'(mm % 10)});
  endtask

  initial begin
    tick(2);
    check("rst_state", set_state, 0);
    check_time("rst", 0, 0);
    check("rst_strobes", {ld_time, ld_alarm, stop_al, al_on}, 0);
    reset = 1'b0;
    tick(1);

    pulse(INC, 1);
    check_time("idle_inc_ignored", 0, 0);

    // time set to 10:20
    btns = SET; tick(1);
    check("enter_t_hr", set_state, 1);
    btns = '0; tick(1);
    pulse(INC, 10);
    check_time("hr_ten", 10, 0);
    pulse(SET, 1);
    check("t_min", set_state, 2);
    pulse(INC, 20);
    check_time("min_twenty", 10, 20);
    btns = SET; tick(1);
    check("t_load", set_state, 3);
    cnt_a = int'(ld_time); cnt_b = int'(ld_alarm);
    btns = '0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      cnt_a += int'(ld_time); cnt_b += int'(ld_alarm);
    end
    check("ld_time_len", cnt_a, 2);
    check("ld_alarm_quiet", cnt_b, 0);
    check("after_load_idle", set_state, 0);
    check_time("loaded", 10, 20);

    // build 23:59, load it, then wrap each field
    pulse(SET, 1);
    pulse(INC, 13);
    pulse(SET, 1);
    pulse(INC, 39);
    check_time("at_2359", 23, 59);
    pulse(SET, 1);
    tick(4);
    pulse(SET, 1);
    pulse(INC, 1);
    check_time("hr_wrap", 0, 59);
    pulse(SET, 1);
    pulse(INC, 1);
    check_time("min_wrap", 0, 0);
    tick(40);
    check("min_timeout_idle", set_state, 0);

    // timeout boundary
    btns = SET; tick(1);
    btns = '0;
    cnt_a = 0;
    for (int i = 0; i < 29; i++) begin
      tick(1);
      cnt_a += int'(ld_time) + int'(ld_alarm);
    end
    check("tmo_29_still_hr", set_state, 1);
    tick(1);
    check("tmo_30_idle", set_state, 0);
    check("tmo_no_strobe", cnt_a + int'(ld_time) + int'(ld_alarm), 0);
    check_time("tmo_digits_kept", 0, 0);

    // alarm set with auto-repeat
    pulse(ASET, 1);
    check("a_hr", set_state, 4);
    btns = INC; tick(18);
    btns = '0; tick(1);
    check_time("repeat_6", 6, 0);
    pulse(ASET, 1);
    check("a_min", set_state, 5);
    btns = ASET; tick(1);
    check("a_load", set_state, 6);
    cnt_a = int'(ld_time); cnt_b = int'(ld_alarm);
    btns = '0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      cnt_a += int'(ld_time); cnt_b += int'(ld_alarm);
    end
    check("ld_alarm_len", cnt_b, 2);
    check("ld_time_quiet", cnt_a, 0);

    // simultaneous presses
    pulse(SET, 1);
    btns = SET | INC; tick(1);
    check("adv_beats_inc_state", set_state, 2);
    check_time("adv_beats_inc_digits", 6, 0);
    btns = '0; tick(40);
    btns = SET | ASET; tick(1);
    check("set_beats_aset", set_state, 1);
    btns = '0; tick(40);

    // alarm enable and stop
    btns = AL; tick(1);
    check("al_on_1", al_on, 1);
    btns = '0; tick(1);
    btns = AL; tick(1);
    check("al_on_0", al_on, 0);
    btns = STOP; tick(1);
    check("stop_latency", stop_al, 1);
    cnt_a = int'(stop_al);
    for (int i = 0; i < 6; i++) begin
      if (i == 4) btns = '0;
      tick(1);
      cnt_a += int'(stop_al);
    end
    check("stop_one_cycle", cnt_a, 1);

    // reset during T_LOAD
    pulse(SET, 2);
    btns = SET; tick(1);
    check("pre_rst_ld_time", ld_time, 1);
    btns = '0; reset = 1'b1; tick(1);
    check("rst_drops_ld", ld_time, 0);
    check("rst_state_idle", set_state, 0);
    reset = 1'b0;
    cnt_a = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      cnt_a += int'(ld_time);
    end
    check("no_partial_load", cnt_a, 0);
    check_time("rst_digits", 0, 0);

    // button held through reset presses on the first cycle after it
    btns = SET; reset = 1'b1; tick(2);
    check("held_in_reset", set_state, 0);
    reset = 1'b0; tick(1);
    check("held_after_reset", set_state, 1);
    btns = '0; tick(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
